// File: rtl/program_loader.sv
// Host-side program loader and result dumper for the A-RISC CPU: streams machine code into
// IRAM, kicks the CPU, waits for it to go idle again, then streams every DRAM byte out.
module program_loader #(
    parameter int unsigned W_ADDR      = 8,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,

    output logic              iram_sel,
    output logic              iram_write,
    output logic [W_ADDR-1:0] iram_addr,
    output logic [15:0]       iram_din,

    output logic              dram_sel,
    output logic [W_ADDR-1:0] dram_addr,
    input  logic [7:0]        dram_dout,

    output logic              start,
    input  logic              idle,

    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,

    output logic              done,
    output logic              err
);

    // The dump path captures dram_dout at the end of the single RD cycle.
    if (RAM_LATENCY != 1) begin : g_unsupported_latency
        $error("program_loader: only RAM_LATENCY = 1 is supported");
    end

    localparam logic [W_ADDR-1:0] LAST_ADDR = '1;

    localparam logic [3:0] LOAD_LO   = 4'd0;
    localparam logic [3:0] LOAD_HI   = 4'd1;
    localparam logic [3:0] WRITE     = 4'd2;
    localparam logic [3:0] START     = 4'd3;
    localparam logic [3:0] WAIT_BUSY = 4'd4;
    localparam logic [3:0] WAIT_IDLE = 4'd5;
    localparam logic [3:0] RD        = 4'd6;
    localparam logic [3:0] SEND      = 4'd7;
    localparam logic [3:0] DONE      = 4'd8;
    localparam logic [3:0] ERR       = 4'd9;

    logic [3:0]        state_q, state_d;
    logic [W_ADDR-1:0] wptr_q, wptr_d;
    logic [W_ADDR-1:0] rptr_q, rptr_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        operand_q, operand_d;
    logic [7:0]        data_q, data_d;

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        data_d    = data_q;
        case (state_q)
            LOAD_LO: begin
                if (s_valid) begin
                    opcode_d = s_data;
                    state_d  = LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (s_valid) begin
                    operand_d = s_data;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (opcode_q == 8'h00) begin
                    state_d = START;
                end else if (wptr_q == LAST_ADDR) begin
                    state_d = ERR;
                end else begin
                    wptr_d  = wptr_q + W_ADDR'(1);
                    state_d = LOAD_LO;
                end
            end
            START: state_d = WAIT_BUSY;
            // A stale idle=1 may linger until the CPU has actually taken the start pulse.
            WAIT_BUSY: begin
                if (!idle) state_d = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (idle) begin
                    rptr_d  = '0;
                    state_d = RD;
                end
            end
            RD: begin
                data_d  = dram_dout;
                state_d = SEND;
            end
            SEND: begin
                if (m_ready) begin
                    if (rptr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        rptr_d  = rptr_q + W_ADDR'(1);
                        state_d = RD;
                    end
                end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = LOAD_LO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD_LO;
            wptr_q    <= '0;
            rptr_q    <= '0;
            opcode_q  <= 8'h00;
            operand_q <= 8'h00;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            data_q    <= data_d;
        end
    end

    assign s_ready    = (state_q == LOAD_LO) || (state_q == LOAD_HI);
    assign iram_sel   = (state_q == LOAD_LO) || (state_q == LOAD_HI) || (state_q == WRITE);
    assign iram_write = (state_q == WRITE);
    assign iram_addr  = wptr_q;
    assign iram_din   = {operand_q, opcode_q};
    assign start      = (state_q == START);
    assign dram_sel   = (state_q == RD) || (state_q == SEND);
    assign dram_addr  = rptr_q;
    assign m_valid    = (state_q == SEND);
    assign m_data     = data_q;
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: mock IRAM write log, preloaded DRAM, scripted CPU idle.
module tb_program_loader;

    localparam int unsigned W_ADDR = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [7:0]        s_data = 8'h00;
    logic              iram_sel;
    logic              iram_write;
    logic [W_ADDR-1:0] iram_addr;
    logic [15:0]       iram_din;
    logic              dram_sel;
    logic [W_ADDR-1:0] dram_addr;
    logic [7:0]        dram_dout;
    logic              start;
    logic              idle = 1'b1;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [7:0]        m_data;
    logic              done;
    logic              err;

    program_loader #(
        .W_ADDR      (W_ADDR),
        .RAM_LATENCY (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .iram_sel   (iram_sel),
        .iram_write (iram_write),
        .iram_addr  (iram_addr),
        .iram_din   (iram_din),
        .dram_sel   (dram_sel),
        .dram_addr  (dram_addr),
        .dram_dout  (dram_dout),
        .start      (start),
        .idle       (idle),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    logic [7:0] dram [256];
    assign dram_dout = dram[dram_addr];

    int unsigned vec_cnt = 0;
    int unsigned miscompares = 0;

    int unsigned cyc = 0;
    logic [7:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int unsigned wr_cyc_q [$];
    int unsigned start_cyc_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (iram_write) begin
            wr_addr_q.push_back(iram_addr);
            wr_data_q.push_back(iram_din);
            wr_cyc_q.push_back(cyc);
        end
        if (start) start_cyc_q.push_back(cyc);
    end

    typedef struct {
        logic [7:0]  opcode;
        logic [7:0]  operand;
        logic [15:0] exp_word;
    } word_vec_t;

    word_vec_t prog [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vec_cnt++;
        miscompares++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        idle = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one byte after an optional stall; returns at the negedge after its handshake.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit is_operand,
                             inout int stall_writes);
        int n;
        if (gap > 0) begin
            s_valid = 1'b0;
            for (int i = 0; i < gap; i++) begin
                @(negedge clk);
                if (is_operand && iram_write) stall_writes++;
            end
        end
        s_valid = 1'b1;
        s_data = b;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) timeout("s_ready wait");
        else @(negedge clk);
    endtask

    task automatic load_program(input bit stall, input string tag);
        int base, sbase, n, stall_writes, last;
        base = wr_addr_q.size();
        sbase = start_cyc_q.size();
        stall_writes = 0;
        for (int i = 0; i < 3; i++) begin
            send_byte(prog[i].opcode, stall ? int'($urandom_range(4, 1)) : 0, 1'b0, stall_writes);
            send_byte(prog[i].operand, stall ? int'($urandom_range(4, 1)) : 0, 1'b1, stall_writes);
        end
        s_valid = 1'b0;
        n = 0;
        while (start_cyc_q.size() == sbase && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (start_cyc_q.size() == sbase) begin
            timeout({tag, " start"});
        end else begin
            check({tag, " write count"}, wr_addr_q.size() - base, 3);
            for (int i = 0; i < 3; i++) begin
                if (base + i < wr_addr_q.size()) begin
                    check({tag, " write addr"}, wr_addr_q[base + i], i);
                    check({tag, " write word"}, wr_data_q[base + i], prog[i].exp_word);
                end
            end
            last = wr_cyc_q.size() - 1;
            check({tag, " start timing"}, start_cyc_q[sbase], wr_cyc_q[last] + 1);
            check({tag, " start pulse width"}, start, 0);
            if (stall) check({tag, " write during stall"}, stall_writes, 0);
        end
    endtask

    task automatic cpu_handshake();
        int stale;
        stale = 0;
        idle = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (dram_sel) stale++;
        end
        idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dram_sel) stale++;
        end
        check("dram_sel before idle return", stale, 0);
        idle = 1'b1;
        @(negedge clk);
        check("dram_sel after idle return", dram_sel, 1);
    endtask

    // Accept bytes under random backpressure until stop_at bytes have been taken.
    task automatic dump(input int stop_at);
        int idx, n, unstable, gap_err;
        bit held, gap;
        logic [7:0] hv, e;
        idx = 0; n = 0; unstable = 0; gap_err = 0; held = 0; gap = 0; hv = 8'h00;
        while (idx < stop_at && n < 3000) begin
            if (gap && m_valid) gap_err++;
            gap = 0;
            if (m_valid && held && m_data !== hv) unstable++;
            m_ready = 1'($urandom_range(1, 0));
            if (m_valid && m_ready) begin
                e = 8'(idx) ^ 8'hA5;
                check("dump byte", m_data, e);
                idx++;
                held = 0;
                gap = 1;
            end else if (m_valid) begin
                held = 1;
                hv = m_data;
            end else begin
                held = 0;
            end
            @(negedge clk);
            n++;
        end
        m_ready = 1'b0;
        if (idx < stop_at) timeout("dump");
        check("m_data stable under backpressure", unstable, 0);
        check("RD cycle between bytes", gap_err, 0);
    endtask

    initial begin
        int base, sbase, seq_err;
        logic [7:0] e100;

        prog[0] = '{opcode: 8'h11, operand: 8'h22, exp_word: 16'h2211};
        prog[1] = '{opcode: 8'h33, operand: 8'h44, exp_word: 16'h4433};
        prog[2] = '{opcode: 8'h00, operand: 8'h55, exp_word: 16'h5500};
        for (int i = 0; i < 256; i++) dram[i] = 8'(i) ^ 8'hA5;

        do_reset();
        check("reset s_ready", s_ready, 1);
        check("reset iram_sel", iram_sel, 1);
        check("reset iram_write", iram_write, 0);
        check("reset iram_addr", iram_addr, 0);
        check("reset iram_din", iram_din, 0);
        check("reset start", start, 0);
        check("reset dram_sel", dram_sel, 0);
        check("reset dram_addr", dram_addr, 0);
        check("reset m_valid", m_valid, 0);
        check("reset m_data", m_data, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);

        // Basic load, CPU handshake, full dump with backpressure.
        load_program(1'b0, "basic");
        check("iram_sel released", iram_sel, 0);
        cpu_handshake();
        dump(256);
        check("done after dump", done, 1);
        check("m_valid after dump", m_valid, 0);
        check("dram_sel after dump", dram_sel, 0);
        check("s_ready after dump", s_ready, 0);

        // Stalled load, then reset while byte 100 is pending.
        do_reset();
        load_program(1'b1, "stall");
        cpu_handshake();
        dump(100);
        @(negedge clk);
        e100 = 8'd100 ^ 8'hA5;
        check("byte 100 presented", m_valid, 1);
        check("byte 100 value", m_data, e100);
        #2 rst = 1'b1;
        #1;
        check("async reset m_valid", m_valid, 0);
        check("async reset done", done, 0);
        check("async reset dram_sel", dram_sel, 0);
        check("async reset iram_sel", iram_sel, 1);
        @(negedge clk);
        rst = 1'b0;
        load_program(1'b0, "reload");

        // Overflow: 256 non-halt words.
        do_reset();
        base = wr_addr_q.size();
        sbase = start_cyc_q.size();
        seq_err = 0;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h01, 0, 1'b0, seq_err);
            send_byte(8'(i), 0, 1'b1, seq_err);
        end
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("overflow write count", wr_addr_q.size() - base, 256);
        for (int i = 0; i < 256; i++) begin
            if (base + i < wr_addr_q.size() && wr_addr_q[base + i] !== 8'(i)) seq_err++;
        end
        check("overflow address sequence", seq_err, 0);
        check("overflow err", err, 1);
        check("overflow start never", start_cyc_q.size() - sbase, 0);
        check("overflow s_ready", s_ready, 0);
        check("overflow iram_sel", iram_sel, 0);
        s_valid = 1'b1;
        s_data = 8'h77;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        check("overflow no consume", wr_addr_q.size() - base, 256);
        check("overflow err sticky", err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
